// File: rtl/iobus_uart_pkg.sv
// Shared types and constants for the IOBUS UART transmitter.
// State encoding, register word selects and STATUS bit positions.
package iobus_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Register selects, taken from IOBUS_ADDR[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_INT_EN = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_DONE    = 3;
    localparam int STAT_OVF     = 4;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_PAR     = 12;

endpackage

// File: rtl/iobus_uart_tx_if.sv
// OTTER IOBUS as seen by a peripheral: MCU is master, the UART is slave.
// Reads are combinational from IOBUS_ADDR; writes are single-cycle strobes.
interface iobus_uart_tx_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;

    modport master (output IOBUS_ADDR, output IOBUS_OUT, output IOBUS_WR, input IOBUS_IN);
    modport slave  (input IOBUS_ADDR, input IOBUS_OUT, input IOBUS_WR, output IOBUS_IN);
endinterface

// File: rtl/uart_tx_fifo.sv
// Purpose: synchronous byte FIFO with occupancy count.
// Latency: push visible one edge later; pop data is combinational from the head.
// Backpressure: push while full (without a same-edge pop) is dropped and flagged on push_drop.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           push_vld,
    input  logic [WIDTH-1:0]               push_dat,
    output logic                           push_drop,
    input  logic                           pop_rdy,
    output logic [WIDTH-1:0]               pop_dat,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign cnt     = cnt_q;
    assign pop_dat = mem[rd_ptr_q];

    // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
    assign do_pop    = pop_rdy && !empty;
    assign do_push   = push_vld && (!full || do_pop);
    assign push_drop = push_vld && !do_push;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/iobus_uart_tx.sv
// Purpose: memory-mapped 8N1 UART transmitter on the OTTER IOBUS (IOBUS_UART_PARITY_EN adds an even parity bit).
// Latency: TXDATA write at edge E0 into an idle, empty block drives the start bit from edge E1.
// Backpressure: none on the bus; writes to a full FIFO are dropped and latched in STATUS.OVF.
module iobus_uart_tx
    import iobus_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd867
) (
    input  logic            CLK,
    input  logic            RST_N,
    iobus_uart_tx_if.slave  bus,
    output logic            INTR,
    output logic            TX
);
    localparam int CW = $clog2(FIFO_DEPTH+1);

`ifdef IOBUS_UART_PARITY_EN
    localparam tx_state_e AFTER_DATA = ST_PARITY;
`else
    localparam tx_state_e AFTER_DATA = ST_STOP;
`endif

    tx_state_e   state_q, state_d;
    logic [15:0] baud_cnt_q, baud_cnt_d;
    logic [15:0] div_lat_q, div_lat_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        int_en_q, int_en_d;
    logic [15:0] baud_div_q, baud_div_d;
`ifdef IOBUS_UART_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic          hit, wr_hit;
    logic [1:0]    sel;
    logic          fifo_push, fifo_drop, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dat;
    logic [CW-1:0] fifo_cnt;
    logic          bit_done, done_set;
    logic [31:0]   status_rd;
    logic          unused_bits;

    assign hit         = (bus.IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign sel         = bus.IOBUS_ADDR[3:2];
    assign wr_hit      = bus.IOBUS_WR && hit;
    assign fifo_push   = wr_hit && (sel == REG_TXDATA);
    assign bit_done    = (baud_cnt_q == div_lat_q);
    assign INTR        = done_q & int_en_q;
    assign unused_bits = ^{bus.IOBUS_ADDR[1:0], bus.IOBUS_OUT[31:16]};

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push_vld  (fifo_push),
        .push_dat  (bus.IOBUS_OUT[7:0]),
        .push_drop (fifo_drop),
        .pop_rdy   (fifo_pop),
        .pop_dat   (fifo_dat),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .cnt       (fifo_cnt)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (!fifo_empty) state_d = ST_START;
            ST_START:  if (bit_done) state_d = ST_DATA;
            ST_DATA:   if (bit_done && bit_idx_q == 3'd7) state_d = AFTER_DATA;
            ST_PARITY: if (bit_done) state_d = ST_STOP;
            ST_STOP:   if (bit_done) state_d = fifo_empty ? ST_IDLE : ST_START;
            default:   state_d = ST_IDLE;
        endcase
    end

    // The stop-bit pop lets the next frame start with no idle gap.
    always_comb begin
        TX       = 1'b1;
        fifo_pop = 1'b0;
        done_set = 1'b0;
        case (state_q)
            ST_IDLE:  fifo_pop = !fifo_empty;
            ST_START: TX = 1'b0;
            ST_DATA:  TX = shift_q[0];
`ifdef IOBUS_UART_PARITY_EN
            ST_PARITY: TX = parity_q;
`endif
            ST_STOP: begin
                if (bit_done) begin
                    fifo_pop = !fifo_empty;
                    done_set = fifo_empty;
                end
            end
            default: ;
        endcase
    end

    // Divisor is latched at frame start so BAUD_DIV writes mid-frame take effect on the next frame.
    always_comb begin
        baud_cnt_d = baud_cnt_q;
        div_lat_d  = div_lat_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
`ifdef IOBUS_UART_PARITY_EN
        parity_d   = parity_q;
`endif
        if (fifo_pop) begin
            baud_cnt_d = '0;
            div_lat_d  = baud_div_q;
            shift_d    = fifo_dat;
            bit_idx_d  = '0;
`ifdef IOBUS_UART_PARITY_EN
            parity_d   = ^fifo_dat;
`endif
        end else if (state_q != ST_IDLE) begin
            if (bit_done) begin
                baud_cnt_d = '0;
                if (state_q == ST_DATA) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end else begin
                baud_cnt_d = baud_cnt_q + 16'd1;
            end
        end
    end

    // Sticky flags: a set on the same edge as a write-1-to-clear wins.
    always_comb begin
        done_d     = done_q;
        ovf_d      = ovf_q;
        int_en_d   = int_en_q;
        baud_div_d = baud_div_q;
        if (wr_hit && sel == REG_STATUS) begin
            if (bus.IOBUS_OUT[STAT_DONE]) done_d = 1'b0;
            if (bus.IOBUS_OUT[STAT_OVF])  ovf_d  = 1'b0;
        end
        if (done_set)  done_d = 1'b1;
        if (fifo_drop) ovf_d  = 1'b1;
        if (wr_hit && sel == REG_BAUD)   baud_div_d = bus.IOBUS_OUT[15:0];
        if (wr_hit && sel == REG_INT_EN) int_en_d   = bus.IOBUS_OUT[0];
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            baud_cnt_q <= '0;
            div_lat_q  <= DIV_RESET;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            int_en_q   <= 1'b0;
            baud_div_q <= DIV_RESET;
`ifdef IOBUS_UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            baud_cnt_q <= baud_cnt_d;
            div_lat_q  <= div_lat_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            int_en_q   <= int_en_d;
            baud_div_q <= baud_div_d;
`ifdef IOBUS_UART_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    always_comb begin
        status_rd                       = '0;
        status_rd[STAT_BUSY]            = (state_q != ST_IDLE);
        status_rd[STAT_FULL]            = fifo_full;
        status_rd[STAT_EMPTY]           = fifo_empty;
        status_rd[STAT_DONE]            = done_q;
        status_rd[STAT_OVF]             = ovf_q;
        status_rd[STAT_CNT_LSB +: 4]    = 4'(fifo_cnt);
`ifdef IOBUS_UART_PARITY_EN
        status_rd[STAT_PAR]             = 1'b1;
`endif
        bus.IOBUS_IN = '0;
        if (hit) begin
            case (sel)
                REG_STATUS: bus.IOBUS_IN = status_rd;
                REG_BAUD:   bus.IOBUS_IN = {16'd0, baud_div_q};
                REG_INT_EN: bus.IOBUS_IN = {31'd0, int_en_q};
                default:    bus.IOBUS_IN = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Scoreboarded bench for iobus_uart_tx: bytes written are queued, the serial monitor pops and compares.
module tb_iobus_uart_tx;
    localparam logic [31:0] BASE = 32'h1100_0100;
`ifdef IOBUS_UART_PARITY_EN
    localparam int          FBITS = 11;
    localparam logic [31:0] PBIT  = 32'h0000_1000;
`else
    localparam int          FBITS = 10;
    localparam logic [31:0] PBIT  = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic intr, tx;
    int   n_vec = 0;
    int   n_err = 0;
    logic [7:0] exp_q[$];

    iobus_uart_tx_if bus();

    iobus_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DIV_RESET(16'd867)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus),
        .INTR  (intr),
        .TX    (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bus.IOBUS_ADDR = a;
        bus.IOBUS_OUT  = d;
        bus.IOBUS_WR   = 1'b1;
        @(posedge clk);
        #1;
        bus.IOBUS_WR   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.IOBUS_ADDR = a;
        #1;
        check(tag, bus.IOBUS_IN, exp);
    endtask

    task automatic send(input logic [7:0] b, input bit accepted);
        if (accepted) exp_q.push_back(b);
        bus_wr(BASE, {24'd0, b});
    endtask

    task automatic wait_start(input int limit, output bit found);
        found = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (tx == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        check("frame_start", {31'd0, found}, 32'd1);
    endtask

    // Entered at the first negedge showing the start bit; samples each bit near its centre.
    task automatic sample_frame(input int p, output time t0);
        logic [7:0] got;
        logic [7:0] e;
        t0 = $time;
        repeat ((p - 1) / 2) @(negedge clk);
        check("start_bit", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (p) @(negedge clk);
            got[i] = tx;
        end
        check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
`ifdef IOBUS_UART_PARITY_EN
        repeat (p) @(negedge clk);
        check("parity_bit", {31'd0, tx}, {31'd0, ^e});
`endif
        repeat (p) @(negedge clk);
        check("stop_bit", {31'd0, tx}, 32'd1);
        check("rx_byte", {24'd0, got}, {24'd0, e});
    endtask

    task automatic recv(input int n, input int p, input bit contig);
        time t0, tp;
        bit  found;
        tp = 0;
        for (int k = 0; k < n; k++) begin
            wait_start(4000, found);
            if (found) begin
                sample_frame(p, t0);
                if (contig && k > 0) check("frame_gap", 32'((t0 - tp) / 10), FBITS * p);
                tp = t0;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        time t_dummy;
        int  lows;
        bus.IOBUS_ADDR = '0;
        bus.IOBUS_OUT  = '0;
        bus.IOBUS_WR   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset values, then reset asserted in the middle of a frame
        rd_chk("rst_status", BASE + 32'h4, 32'h4 | PBIT);
        rd_chk("rst_baud", BASE + 32'h8, 32'd867);
        rd_chk("rst_int_en", BASE + 32'hC, 32'd0);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_intr", {31'd0, intr}, 32'd0);
        bus_wr(BASE, 32'h55);
        repeat (20) @(negedge clk);
        check("midframe_tx", {31'd0, tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1 check("async_rst_tx", {31'd0, tx}, 32'd1);
        rd_chk("midrst_status", BASE + 32'h4, 32'h4 | PBIT);
        rd_chk("midrst_baud", BASE + 32'h8, 32'd867);
        check("midrst_intr", {31'd0, intr}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 0xA5 at BAUD_DIV=3 with start-bit latency and interrupt enabled
        bus_wr(BASE + 32'h8, 32'd3);
        bus_wr(BASE + 32'hC, 32'd1);
        rd_chk("rd_txdata", BASE, 32'd0);
        send(8'hA5, 1'b1);
        @(negedge clk);
        check("lat_e0_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        check("lat_e1_tx", {31'd0, tx}, 32'd0);
        sample_frame(4, t_dummy);
        repeat (4) @(negedge clk);
        rd_chk("a5_status", BASE + 32'h4, 32'hC | PBIT);
        check("a5_intr", {31'd0, intr}, 32'd1);

        // W1C of DONE/OVF and out-of-window reads
        bus_wr(BASE + 32'h4, 32'h18);
        @(negedge clk);
        check("w1c_intr", {31'd0, intr}, 32'd0);
        rd_chk("w1c_status", BASE + 32'h4, 32'h4 | PBIT);
        rd_chk("oow_hi", 32'h1100_0204, 32'd0);
        rd_chk("oow_lo", 32'h1100_00F8, 32'd0);
        bus_wr(BASE + 32'hC, 32'd0);

        // Nine back-to-back writes fill the FIFO without overflow
        fork
            begin
                for (int i = 0; i < 9; i++) send(8'h30 + 8'(i), 1'b1);
                rd_chk("nine_status", BASE + 32'h4, 32'h803 | PBIT);
            end
            recv(9, 4, 1'b1);
        join
        repeat (4) @(negedge clk);
        rd_chk("nine_done", BASE + 32'h4, 32'hC | PBIT);
        check("nine_intr_masked", {31'd0, intr}, 32'd0);
        bus_wr(BASE + 32'h4, 32'h18);

        // Ten writes: the last is dropped and OVF latches
        fork
            begin
                for (int i = 0; i < 10; i++) send(8'hC0 ^ 8'(i * 7), i < 9);
                rd_chk("ten_status", BASE + 32'h4, 32'h813 | PBIT);
            end
            recv(9, 4, 1'b1);
        join
        repeat (4) @(negedge clk);
        rd_chk("ten_done", BASE + 32'h4, 32'h1C | PBIT);
        lows = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx == 1'b0) lows++;
        end
        check("no_extra_frame", lows, 32'd0);
        bus_wr(BASE + 32'h4, 32'h18);

        // Contiguous frames at BAUD_DIV=1
        bus_wr(BASE + 32'h8, 32'd1);
        fork
            begin
                send(8'h01, 1'b1);
                send(8'h02, 1'b1);
            end
            recv(2, 2, 1'b1);
        join
        repeat (4) @(negedge clk);
        rd_chk("b2b_status", BASE + 32'h4, 32'hC | PBIT);

        // 0x07 carries odd weight, so parity builds must send a 1
        fork
            send(8'h07, 1'b1);
            recv(1, 2, 1'b0);
        join
        repeat (4) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
